// File: rtl/pca9685_servo_sequencer.sv
// pca9685_servo_sequencer
//   Sequences PCA9685 register writes for a group of servo channels.
//   After reset it runs the chip init: MODE1 sleep, PRE_SCALE, MODE1 run.
//   It then sweeps the channels once per refresh tick. Each sweep writes the
//   four ON/OFF registers only for channels whose pulse width changed.
//   Writes are handed to an external I2C frame engine through a
//   request/done handshake.
//
//   Build option: define SERVO_CLAMP_EN to clamp every channel value to
//   [MIN_CNT, MAX_CNT] before it is compared and written.
//
// Ports
//   i_clk, i_rst   clock; asynchronous active-high reset
//   i_enable       1 = new sweeps may start
//   i_force        pulse: the next sweep rewrites every channel
//   i_pulse        12-bit OFF count per channel (ch c at [12c+11:12c])
//   o_wr_req       byte-write request, held until i_wr_done is sampled
//   o_reg_addr     register address, valid while o_wr_req is high
//   o_wr_data      register data, valid while o_wr_req is high
//   i_wr_done      one-cycle completion pulse from the frame engine
//   i_wr_err       qualified by i_wr_done: the write failed
//   o_ready        init sequence complete
//   o_busy         sequencer is doing anything other than waiting for a tick
//   o_err          sticky write-failure flag
module pca9685_servo_sequencer #(
  parameter int          N_CH        = 4,
  parameter int          CH_BASE     = 0,
  parameter logic [7:0]  PRESCALE    = 8'h79,
  parameter int          REFRESH_DIV = 1000000,
  parameter logic [11:0] MIN_CNT     = 12'd102,
  parameter logic [11:0] MAX_CNT     = 12'd512
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_force,
  input  logic [12*N_CH-1:0] i_pulse,
  output logic              o_wr_req,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_done,
  input  logic              i_wr_err,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CH_W   = $clog2(N_CH) + 1;
  localparam int TICK_W = $clog2(REFRESH_DIV);

`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_INIT_SLEEP,
    S_INIT_PRE,
    S_INIT_RUN,
    S_WAIT_TICK,
    S_SCAN,
    S_WR_ONL,
    S_WR_ONH,
    S_WR_OFFL,
    S_WR_OFFH
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [11:0]       snap_q, snap_d;
  logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
  logic              tickPending_q, tickPending_d;
  logic              forcePending_q, forcePending_d;
  logic              forceLatched_q, forceLatched_d;
  logic              req_q, req_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [11:0]       shadow_q [N_CH];
  logic [N_CH-1:0]   shadowValid_q;
  logic              shadowWr;
  logic              shadowInv;

  logic [11:0]       pulseEff [N_CH];
  logic [11:0]       curPulse;
  logic [11:0]       curShadow;
  logic              curValid;
  logic              dirty;
  logic              tickWrap;
  logic              isWrite;
  logic [7:0]        chIdx;
  logic [7:0]        ledBase;
  logic [7:0]        wAddr;
  logic [7:0]        wData;

  // Effective per-channel value, optionally clamped.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      pulseEff[c] = i_pulse[12*c +: 12];
      if (CLAMP_EN) begin
        if (pulseEff[c] < MIN_CNT) begin
          pulseEff[c] = MIN_CNT;
        end else if (pulseEff[c] > MAX_CNT) begin
          pulseEff[c] = MAX_CNT;
        end
      end
    end
  end

  // Select the value and shadow of the channel under the scan pointer.
  // The pointer runs one past the last channel, which selects nothing.
  always_comb begin
    curPulse  = '0;
    curShadow = '0;
    curValid  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        curPulse  = pulseEff[c];
        curShadow = shadow_q[c];
        curValid  = shadowValid_q[c];
      end
    end
    dirty = !curValid || forceLatched_q || (curPulse != curShadow);
  end

  // Register address and data for the write owned by the current state.
  always_comb begin
    chIdx   = 8'(CH_BASE) + 8'(ch_q);
    ledBase = 8'h06 + (chIdx << 2);
    wAddr   = 8'h00;
    wData   = 8'h00;
    isWrite = 1'b1;
    case (state_q)
      S_INIT_SLEEP: begin wAddr = 8'h00;          wData = 8'h10; end
      S_INIT_PRE:   begin wAddr = 8'hFE;          wData = PRESCALE; end
      S_INIT_RUN:   begin wAddr = 8'h00;          wData = 8'h00; end
      S_WR_ONL:     begin wAddr = ledBase;        wData = 8'h00; end
      S_WR_ONH:     begin wAddr = ledBase + 8'd1; wData = 8'h00; end
      S_WR_OFFL:    begin wAddr = ledBase + 8'd2; wData = snap_q[7:0]; end
      S_WR_OFFH:    begin wAddr = ledBase + 8'd3; wData = {4'h0, snap_q[11:8]}; end
      default:      isWrite = 1'b0;
    endcase
  end

  // Next-state logic. A write state raises its request in the first cycle
  // it sees the request low, so consecutive writes always leave one idle
  // cycle. A dirty channel found in S_SCAN raises the ON_L request straight
  // away, which keeps the gap at one cycle across channel groups as well.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    snap_d         = snap_q;
    req_d          = req_q;
    addr_d         = addr_q;
    data_d         = data_q;
    ready_d        = ready_q;
    err_d          = err_q;
    shadowWr       = 1'b0;
    shadowInv      = 1'b0;
    tickWrap       = (tickCnt_q == TICK_W'(REFRESH_DIV - 1));
    tickCnt_d      = tickWrap ? '0 : tickCnt_q + TICK_W'(1);
    tickPending_d  = tickPending_q | tickWrap;
    forcePending_d = forcePending_q | i_force;
    forceLatched_d = forceLatched_q;

    if (isWrite) begin
      if (!req_q) begin
        req_d  = 1'b1;
        addr_d = wAddr;
        data_d = wData;
      end else if (i_wr_done) begin
        req_d = 1'b0;
        if (i_wr_err) begin
          err_d   = 1'b1;
          ready_d = 1'b0;
          state_d = S_INIT_SLEEP;
        end else begin
          case (state_q)
            S_INIT_SLEEP: state_d = S_INIT_PRE;
            S_INIT_PRE:   state_d = S_INIT_RUN;
            S_INIT_RUN: begin
              ready_d   = 1'b1;
              shadowInv = 1'b1;
              state_d   = S_WAIT_TICK;
            end
            S_WR_ONL:     state_d = S_WR_ONH;
            S_WR_ONH:     state_d = S_WR_OFFL;
            S_WR_OFFL:    state_d = S_WR_OFFH;
            S_WR_OFFH: begin
              shadowWr = 1'b1;
              ch_d     = ch_q + CH_W'(1);
              state_d  = S_SCAN;
            end
            default:      state_d = S_INIT_SLEEP;
          endcase
        end
      end
    end else if (state_q == S_WAIT_TICK) begin
      if (tickPending_q && i_enable) begin
        tickPending_d  = tickWrap;
        forceLatched_d = forcePending_q;
        forcePending_d = i_force;
        ch_d           = '0;
        state_d        = S_SCAN;
      end
    end else if (state_q == S_SCAN) begin
      if ((ch_q >= CH_W'(N_CH)) || !i_enable) begin
        forceLatched_d = 1'b0;
        state_d        = S_WAIT_TICK;
      end else if (dirty) begin
        snap_d  = curPulse;
        req_d   = 1'b1;
        addr_d  = ledBase;
        data_d  = 8'h00;
        state_d = S_WR_ONL;
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end else begin
      state_d = S_INIT_SLEEP;
    end

    busy_d = (state_d != S_WAIT_TICK);
  end

  // Control and handshake registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_INIT_SLEEP;
      ch_q           <= '0;
      snap_q         <= '0;
      tickCnt_q      <= '0;
      tickPending_q  <= 1'b0;
      forcePending_q <= 1'b0;
      forceLatched_q <= 1'b0;
      req_q          <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      ready_q        <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      snap_q         <= snap_d;
      tickCnt_q      <= tickCnt_d;
      tickPending_q  <= tickPending_d;
      forcePending_q <= forcePending_d;
      forceLatched_q <= forceLatched_d;
      req_q          <= req_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      ready_q        <= ready_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  // Shadow copy of the last value written per channel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadowValid_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        shadow_q[c] <= '0;
      end
    end else if (shadowInv) begin
      shadowValid_q <= '0;
    end else if (shadowWr) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_q == CH_W'(c)) begin
          shadow_q[c]      <= snap_q;
          shadowValid_q[c] <= 1'b1;
        end
      end
    end
  end

  assign o_wr_req   = req_q;
  assign o_reg_addr = addr_q;
  assign o_wr_data  = data_q;
  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_pca9685_servo_sequencer.sv
// tb_pca9685_servo_sequencer
//   Drives pca9685_servo_sequencer with a responder standing in for the I2C
//   frame engine and compares every sweep's writes with a channel-level
//   reference model. Define SERVO_CLAMP_EN for the clamp build.
module tb_pca9685_servo_sequencer;

  localparam int N_CH        = 4;
  localparam int CH_BASE     = 0;
  localparam int REFRESH_DIV = 400;
  localparam int LIMIT       = 3 * REFRESH_DIV;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              forceIn = 1'b0;
  logic [12*N_CH-1:0] pulse = '0;
  logic              wrReq;
  logic [7:0]        regAddr;
  logic [7:0]        wrData;
  logic              wrDone = 1'b0;
  logic              wrErr = 1'b0;
  logic              ready;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Responder state and capture.
  logic [15:0] gotQ[$];
  int          gapQ[$];
  int          lowRun = 0;
  bit          inReq = 1'b0;
  bit          justDone = 1'b0;
  logic [7:0]  capAddr;
  logic [7:0]  capData;
  int          waitCnt = 0;
  int          ackDelay = 3;
  bit          randAck = 1'b0;
  int          writeCount = 0;
  int          errAt = -1;
  bit          errSeen = 1'b0;

  // Reference model state.
  logic [15:0] expQ[$];
  logic [11:0] mShadow [N_CH];
  bit          mValid [N_CH];
  bit          mForce = 1'b0;

  pca9685_servo_sequencer #(
    .N_CH(N_CH),
    .CH_BASE(CH_BASE),
    .PRESCALE(8'h79),
    .REFRESH_DIV(REFRESH_DIV),
    .MIN_CNT(12'd102),
    .MAX_CNT(12'd512)
  ) dut (
    .i_clk(clock),
    .i_rst(reset),
    .i_enable(enable),
    .i_force(forceIn),
    .i_pulse(pulse),
    .o_wr_req(wrReq),
    .o_reg_addr(regAddr),
    .o_wr_data(wrData),
    .i_wr_done(wrDone),
    .i_wr_err(wrErr),
    .o_ready(ready),
    .o_busy(busy),
    .o_err(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frame-engine stand-in: acks each request after a delay, records it,
  // and watches address/data stability and the low gap between requests.
  initial begin
    forever begin
      @(negedge clock);
      wrDone = 1'b0;
      wrErr  = 1'b0;
      if (reset) begin
        inReq    = 1'b0;
        justDone = 1'b0;
        lowRun   = 0;
      end else begin
        if (justDone) begin
          checkOutput("req_drop", {31'd0, wrReq}, 32'd0);
          justDone = 1'b0;
        end
        if (wrReq) begin
          if (!inReq) begin
            inReq   = 1'b1;
            capAddr = regAddr;
            capData = wrData;
            gapQ.push_back(lowRun);
            lowRun  = 0;
            waitCnt = randAck ? int'($urandom_range(0, 3)) : ackDelay - 1;
          end else begin
            checkOutput("req_stable", {16'd0, regAddr, wrData}, {16'd0, capAddr, capData});
          end
          if (waitCnt == 0) begin
            writeCount++;
            wrDone = 1'b1;
            wrErr  = (writeCount == errAt);
            if (wrErr) errSeen = 1'b1;
            gotQ.push_back({capAddr, capData});
            inReq    = 1'b0;
            justDone = 1'b1;
          end else begin
            waitCnt--;
          end
        end else begin
          lowRun++;
        end
      end
    end
  end

  function automatic logic [11:0] effVal(input logic [11:0] raw);
`ifdef SERVO_CLAMP_EN
    if (raw < 12'd102) return 12'd102;
    if (raw > 12'd512) return 12'd512;
`endif
    return raw;
  endfunction

  function automatic logic [7:0] regOf(input int c, input int i);
    return 8'(6 + 4 * (CH_BASE + c) + i);
  endfunction

  task automatic modelInit();
    expQ = {};
    expQ.push_back(16'h0010);
    expQ.push_back(16'hFE79);
    expQ.push_back(16'h0000);
    for (int c = 0; c < N_CH; c++) mValid[c] = 1'b0;
  endtask

  task automatic modelSweep();
    logic [11:0] v;
    expQ = {};
    for (int c = 0; c < N_CH; c++) begin
      v = effVal(pulse[12*c +: 12]);
      if (!mValid[c] || mForce || v != mShadow[c]) begin
        expQ.push_back({regOf(c, 0), 8'h00});
        expQ.push_back({regOf(c, 1), 8'h00});
        expQ.push_back({regOf(c, 2), v[7:0]});
        expQ.push_back({regOf(c, 3), 4'h0, v[11:8]});
        mShadow[c] = v;
        mValid[c]  = 1'b1;
      end
    end
    mForce = 1'b0;
  endtask

  task automatic checkSweep(input string tag);
    int n;
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_write"}, {16'd0, gotQ[i]}, {16'd0, expQ[i]});
    end
    gotQ = {};
    gapQ = {};
  endtask

  task automatic waitSweep(input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < LIMIT) begin @(negedge clock); n++; end
    while (busy !== 1'b0 && n < LIMIT) begin @(negedge clock); n++; end
    checkOutput({tag, "_in_time"}, {31'd0, n < LIMIT}, 32'd1);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < LIMIT) begin @(negedge clock); n++; end
    checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic applyStimulus(input int c, input logic [11:0] v);
    pulse[12*c +: 12] = v;
  endtask

  task automatic pulseForce();
    @(negedge clock);
    forceIn = 1'b1;
    @(negedge clock);
    forceIn = 1'b0;
    mForce  = 1'b1;
  endtask

  initial begin
    int n;
    applyStimulus(0, 12'd300);
    applyStimulus(1, 12'd250);
    applyStimulus(2, 12'd200);
    applyStimulus(3, 12'd150);
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_req", {31'd0, wrReq}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // T1: init sequence with a fixed 3-cycle ack.
    $display("[TB] init sequence");
    waitReady("t1");
    modelInit();
    checkSweep("t1");
    checkOutput("t1_err", {31'd0, err}, 32'd0);
    @(negedge clock);
    enable = 1'b1;

    // T2: first sweep writes every channel, one idle cycle between requests.
    $display("[TB] first full sweep");
    waitSweep("t2");
    if (gotQ.size() >= 4) begin
      checkOutput("t2_ch0_offl", {16'd0, gotQ[2]}, 32'h082C);
      checkOutput("t2_ch0_offh", {16'd0, gotQ[3]}, 32'h0901);
    end else begin
      checkOutput("t2_short", gotQ.size(), 4);
    end
    for (int i = 1; i < gapQ.size(); i++) begin
      checkOutput("t2_gap", gapQ[i], 1);
    end
    modelSweep();
    checkSweep("t2");

    // T3: single-channel change, then an idle sweep.
    $display("[TB] single channel update");
    applyStimulus(2, 12'h1F4);
    waitSweep("t3a");
    modelSweep();
    checkSweep("t3a");
    waitSweep("t3b");
    modelSweep();
    checkSweep("t3b");

    // Randomized channel updates with random ack latency.
    $display("[TB] randomized sweeps");
    randAck = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 1) == 1) applyStimulus(c, 12'($urandom()));
      end
      if (r == 3) pulseForce();
      waitSweep("rnd");
      modelSweep();
      checkSweep("rnd");
    end

    // T4: force with no changes rewrites everything once.
    $display("[TB] forced sweep");
    pulseForce();
    waitSweep("t4a");
    modelSweep();
    checkSweep("t4a");
    waitSweep("t4b");
    modelSweep();
    checkSweep("t4b");

    // T5: failure on the second write of a sweep.
    $display("[TB] write failure");
    applyStimulus(0, pulse[11:0] ^ 12'h001);
    errAt = writeCount + 2;
    n = 0;
    while (!errSeen && n < LIMIT) begin @(negedge clock); n++; end
    checkOutput("t5_err_seen", {31'd0, errSeen}, 32'd1);
    @(negedge clock);
    checkOutput("t5_err", {31'd0, err}, 32'd1);
    checkOutput("t5_ready_low", {31'd0, ready}, 32'd0);
    waitSweep("t5a");
    errAt = -1;
    modelInit();
    expQ.push_front({regOf(0, 1), 8'h00});
    expQ.push_front({regOf(0, 0), 8'h00});
    checkSweep("t5a");
    checkOutput("t5_ready_again", {31'd0, ready}, 32'd1);
    checkOutput("t5_err_sticky", {31'd0, err}, 32'd1);
    waitSweep("t5b");
    modelSweep();
    checkSweep("t5b");

    // T6: reset in the middle of a transaction.
    $display("[TB] reset mid-transaction");
    applyStimulus(1, pulse[23:12] ^ 12'h010);
    n = 0;
    while (wrReq !== 1'b1 && n < LIMIT) begin @(negedge clock); n++; end
    checkOutput("t6_req_seen", {31'd0, wrReq}, 32'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_req", {31'd0, wrReq}, 32'd0);
    checkOutput("t6_err", {31'd0, err}, 32'd0);
    checkOutput("t6_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clock);
    gotQ = {};
    gapQ = {};
    mForce = 1'b0;
    reset = 1'b0;
    waitReady("t6");
    modelInit();
    checkSweep("t6_init");
    waitSweep("t6b");
    modelSweep();
    checkSweep("t6b");

`ifdef SERVO_CLAMP_EN
    // T7: values outside the clamp window.
    $display("[TB] clamp");
    applyStimulus(0, 12'd50);
    applyStimulus(1, 12'd900);
    waitSweep("t7");
    if (gotQ.size() >= 8) begin
      checkOutput("t7_ch0_offl", {16'd0, gotQ[2]}, 32'h0866);
      checkOutput("t7_ch0_offh", {16'd0, gotQ[3]}, 32'h0900);
      checkOutput("t7_ch1_offl", {16'd0, gotQ[6]}, 32'h0C00);
      checkOutput("t7_ch1_offh", {16'd0, gotQ[7]}, 32'h0D02);
    end else begin
      checkOutput("t7_short", gotQ.size(), 8);
    end
    modelSweep();
    checkSweep("t7");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
